// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART word encoder: command codes, ASCII bytes,
// encoder state enum and small helpers for command/first-digit lookup.
package uart_cmd_pkg;

  localparam int unsigned WORD_W    = 34;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NIB_IDX_W = 3;

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_ADDR  = 2'b10;
  localparam logic [1:0] CMD_STAT  = 2'b11;

  localparam logic [7:0] ASCII_R          = 8'h52;
  localparam logic [7:0] ASCII_W          = 8'h57;
  localparam logic [7:0] ASCII_A          = 8'h41;
  localparam logic [7:0] ASCII_S          = 8'h53;
  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_BASE = 8'h61;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_DIGITS = 2'd2,
    ST_TERM   = 2'd3
  } enc_state_e;

  // Command code to its ASCII letter.
  function automatic logic [7:0] cmd_ascii(input logic [1:0] code);
    logic [7:0] ch;
    case (code)
      CMD_READ:  ch = ASCII_R;
      CMD_WRITE: ch = ASCII_W;
      CMD_ADDR:  ch = ASCII_A;
      default:   ch = ASCII_S;
    endcase
    return ch;
  endfunction

  // Index of the most significant nonzero nibble; 0 for a zero value so
  // that a single '0' digit is still emitted.
  function automatic logic [NIB_IDX_W-1:0] first_nibble(input logic [DATA_W-1:0] d);
    logic [NIB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (d[i*4 +: 4] != 4'h0) idx = NIB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_nibble_ascii.sv
// Combinational 4-bit value to lowercase ASCII hex digit.
//   nib_i   : nibble value 0..15
//   ascii_o : '0'..'9' or 'a'..'f'
module uart_nibble_ascii
  import uart_cmd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

  assign ascii_o = (nib_i < 4'd10) ? (ASCII_DIGIT_BASE + 8'(nib_i))
                                   : (ASCII_ALPHA_BASE + 8'(nib_i - 4'd10));

endmodule

// File: rtl/uart_encoder.sv
// Encodes a 34-bit command word as ASCII bytes for a UART transmitter:
// command letter, hex digits (MSB nibble first), then a terminator.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_stb, i_word  : encode request and word ([33:32] cmd, [31:0] data)
//   o_busy         : word in progress
//   o_stb, o_data  : byte offered to transmitter
//   i_tx_busy      : transmitter stall
module uart_encoder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR      = 8'h0A,
  parameter bit         SUPPRESS_ZEROS = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stb,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_busy,
  output logic              o_stb,
  output logic [7:0]        o_data,
  input  logic              i_tx_busy
);

  enc_state_e            state_q, state_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [NIB_IDX_W-1:0]  idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  stb_q, stb_d;
  logic [7:0]            data_q, data_d;
  logic                  xfer_c;
  logic [3:0]            nib_c;
  logic [7:0]            nib_ascii_c;

  assign xfer_c = stb_q & ~i_tx_busy;

  // State, captured word, nibble index and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
    end
  end

  // Next-state and sequencing.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_stb) begin
          state_d = ST_CMD;
          word_d  = i_word;
        end
      end
      ST_CMD: begin
        if (xfer_c) begin
          state_d = ST_DIGITS;
          idx_d   = SUPPRESS_ZEROS ? first_nibble(word_q[DATA_W-1:0])
                                   : NIB_IDX_W'(7);
        end
      end
      ST_DIGITS: begin
        if (xfer_c) begin
          if (idx_q == '0) state_d = ST_TERM;
          else             idx_d   = idx_q - NIB_IDX_W'(1);
        end
      end
      ST_TERM: begin
        if (xfer_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit for the upcoming byte is taken from next-state word and index so
  // the output register updates in lockstep with the state.
  assign nib_c = 4'(word_d[DATA_W-1:0] >> {idx_d, 2'b00});

  uart_nibble_ascii u_nibble_ascii (
    .nib_i   (nib_c),
    .ascii_o (nib_ascii_c)
  );

  // Output next-values, decoded from the next state.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    stb_d  = (state_d != ST_IDLE);
    data_d = 8'h00;
    case (state_d)
      ST_CMD:    data_d = cmd_ascii(word_d[WORD_W-1:DATA_W]);
      ST_DIGITS: data_d = nib_ascii_c;
      ST_TERM:   data_d = TERM_CHAR;
      default:   data_d = 8'h00;
    endcase
  end

  assign o_busy = busy_q;
  assign o_stb  = stb_q;
  assign o_data = data_q;

endmodule

// File: tb/tb_uart_encoder.sv
// Directed self-checking bench for uart_encoder (default and no-suppression).
module tb_uart_encoder;

  logic        clk;
  logic        rst_n;
  logic        stb, stb2;
  logic [33:0] word, word2;
  logic        tx_busy;
  logic        busy, ostb, busy2, ostb2;
  logic [7:0]  odata, odata2;

  int total;
  int bad;
  logic [7:0] exp_q[$];

  uart_encoder dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_stb     (stb),
    .i_word    (word),
    .o_busy    (busy),
    .o_stb     (ostb),
    .o_data    (odata),
    .i_tx_busy (tx_busy)
  );

  uart_encoder #(.TERM_CHAR(8'h0A), .SUPPRESS_ZEROS(1'b0)) dut_nz (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_stb     (stb2),
    .i_word    (word2),
    .o_busy    (busy2),
    .o_stb     (ostb2),
    .o_data    (odata2),
    .i_tx_busy (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends one word to dut and checks every transferred byte against exp_q.
  // toggle: stall the transmitter every other cycle. inj: loop cycle on which
  // a competing request is pulsed (-1 for none).
  task automatic run_word(input logic [33:0] w, input bit toggle, input int inj);
    int         n;
    bit         stall;
    bit         done;
    logic [7:0] prev;
    n = 0; stall = 0; done = 0; prev = 8'h00;
    stb = 1'b1; word = w;
    tick();
    stb = 1'b0;
    chk("latency_stb", 32'(ostb), 32'd1);
    chk("latency_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 200 && !done; c++) begin
      if (c == inj) begin
        stb = 1'b1; word = {2'b11, 32'h1};
      end else begin
        stb = 1'b0;
      end
      if (stall && ostb) chk("hold_stable", 32'(odata), 32'(prev));
      if (!ostb) begin
        done = 1;
      end else begin
        tx_busy = toggle ? ~tx_busy : 1'b0;
        if (!tx_busy) begin
          if (n < exp_q.size()) chk($sformatf("byte%0d", n), 32'(odata), 32'(exp_q[n]));
          else                  chk("extra_byte", 32'(n), 32'(exp_q.size()));
          n++;
          stall = 0;
        end else begin
          stall = 1;
          prev  = odata;
        end
        tick();
      end
    end
    stb = 1'b0; tx_busy = 1'b0;
    chk("byte_count", 32'(n), 32'(exp_q.size()));
    chk("end_busy", 32'(busy), 32'd0);
    tick();
    chk("no_restart", 32'(ostb), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; stb = 1'b0; stb2 = 1'b0; word = '0; word2 = '0; tx_busy = 1'b0;
    tick();
    chk("rst_stb", 32'(ostb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(odata), 32'h00);
    chk("rst_stb_nz", 32'(ostb2), 32'd0);
    rst_n = 1'b1;
    tick();

    // Small value, back-to-back bytes; competing request mid-word is dropped.
    exp_q = '{8'h52, 8'h31, 8'h61, 8'h0A};
    run_word({2'b00, 32'h0000001a}, 1'b0, 1);

    // Zero data emits one '0'; request on the terminator cycle is ignored.
    exp_q = '{8'h57, 8'h30, 8'h0A};
    run_word({2'b01, 32'h0}, 1'b0, 2);

    // Full-width value with the transmitter stalling every other cycle.
    exp_q = '{8'h41, 8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0A};
    run_word({2'b10, 32'hDEADBEEF}, 1'b1, -1);

    // Reset mid-word aborts immediately.
    stb = 1'b1; word = {2'b10, 32'hDEADBEEF};
    tick();
    stb = 1'b0;
    chk("abort_b0", 32'(odata), 32'h41);
    tick();
    chk("abort_b1", 32'(odata), 32'h64);
    tick();
    chk("abort_b2", 32'(odata), 32'h65);
    rst_n = 1'b0;
    #1;
    chk("abort_stb", 32'(ostb), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_data", 32'(odata), 32'h00);
    tick();
    chk("abort_held", 32'(ostb), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(ostb), 32'd0);
    exp_q = '{8'h52, 8'h37, 8'h0A};
    run_word({2'b00, 32'h7}, 1'b0, -1);

    // Fixed-width instance: all eight digits, leading zeros included.
    exp_q = '{8'h53, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h35, 8'h0A};
    stb2 = 1'b1; word2 = {2'b11, 32'h5};
    tick();
    stb2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("nz_stb%0d", i), 32'(ostb2), 32'd1);
      chk($sformatf("nz_byte%0d", i), 32'(odata2), 32'(exp_q[i]));
      tick();
    end
    chk("nz_end_stb", 32'(ostb2), 32'd0);
    chk("nz_end_busy", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_encoder.md
UART_ENCODER -- requirements
Module: uart_encoder

Interface
REQ-001 Parameter: TERM_CHAR, 8'h0A, terminator byte emitted after every word.
REQ-002 Parameter: SUPPRESS_ZEROS, 1, 1 = omit leading zero hex digits; 0 = always emit 8 digits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: i_clk, input, 1, single rising-edge clock.
REQ-005 Port: i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: i_stb, input, 1, request to encode i_word.
REQ-007 Port: i_word, input, 34, [33:32] command code, [31:0] data value.
REQ-008 Port: o_busy, output, 1, high while a word is being encoded.
REQ-009 Port: o_stb, output, 1, o_data holds a valid byte for the UART transmitter.
REQ-010 Port: o_data, output, 8, ASCII byte to transmit.
REQ-011 Port: i_tx_busy, input, 1, transmitter cannot accept a byte this cycle.

Function
REQ-012 The block SHALL accept a word only when i_stb=1 and o_busy=0, capturing i_word in the same cycle.
REQ-013 The block SHALL ignore i_stb while o_busy=1, with no queuing.
REQ-014 The command byte SHALL map from word[33:32] as 00->'R'(8'h52), 01->'W'(8'h57), 10->'A'(8'h41), 11->'S'(8'h53).
REQ-015 Hex digits SHALL be emitted MSB nibble first: 0-9 -> 8'h30-8'h39, a-f -> 8'h61-8'h66, lowercase only.
REQ-016 With SUPPRESS_ZEROS=1, emission SHALL start at the most significant nonzero nibble; data 0 SHALL emit exactly one '0'.
REQ-017 Each word SHALL be emitted as: command byte, hex digits, TERM_CHAR.
REQ-018 A byte SHALL transfer on any rising edge where o_stb=1 and i_tx_busy=0.
REQ-019 o_data SHALL be held stable while o_stb=1 and i_tx_busy=1.
REQ-020 After a transfer, the next byte SHALL be presented on the following cycle, so back-to-back bytes are possible while i_tx_busy=0.
REQ-021 Latency: o_stb SHALL rise with the command byte on the cycle after acceptance.
REQ-022 The state machine SHALL have the states IDLE, CMD, DIGITS and TERM.
REQ-023 Transition IDLE->CMD: on acceptance.
REQ-024 Transition CMD->DIGITS: on transfer; the 3-bit nibble index SHALL load the first-digit position.
REQ-025 Within DIGITS, each transfer SHALL decrement the nibble index; DIGITS->TERM SHALL occur on transfer at index 0.
REQ-026 Transition TERM->IDLE: on transfer.
REQ-027 o_busy SHALL be registered: 1 in CMD, DIGITS and TERM; 0 in IDLE.
REQ-028 o_stb SHALL be 1 in CMD, DIGITS and TERM, and 0 in IDLE.
REQ-029 If i_stb=1 on the cycle the terminator transfers, the request SHALL be ignored because o_busy is still 1.
REQ-030 The nibble index SHALL never wrap below 0.

Reset
REQ-031 On i_rst_n=0 the block SHALL immediately force state=IDLE, o_stb=0, o_busy=0, o_data=8'h00, and clear the captured word and nibble index.
REQ-032 Reset asserted mid-word SHALL abort the word with no further bytes emitted, and the next accepted word SHALL be encoded in full.

Structure
REQ-033 Package uart_cmd_pkg SHALL hold the command codes, the ASCII constants ('R','W','A','S', digit bases 8'h30 and 8'h61) and the state enum.
REQ-034 Sub-module uart_nibble_ascii SHALL provide the combinational 4-bit-to-ASCII conversion; all sequencing SHALL stay in uart_encoder.

Verification
REQ-035 {2'b00,32'h0000001a}, i_tx_busy=0 -> 8'h52, 8'h31, 8'h61, 8'h0A on 4 consecutive cycles starting the cycle after i_stb.
REQ-036 {2'b01,32'h0} -> 8'h57, 8'h30, 8'h0A, then o_busy=0.
REQ-037 {2'b10,32'hDEADBEEF} with i_tx_busy toggling every cycle -> "Adeadbeef" then 8'h0A; o_data stable while i_tx_busy=1; 10 transfers total.
REQ-038 i_stb with {2'b11,32'h1} pulsed mid-word -> ignored; only the first word appears on o_data.
REQ-039 i_rst_n=0 after the 3rd byte of 32'hDEADBEEF -> o_stb=0 immediately; a following {2'b00,32'h7} -> 8'h52, 8'h37, 8'h0A.
REQ-040 SUPPRESS_ZEROS=0, {2'b11,32'h5} -> 8'h53, seven 8'h30, 8'h35, 8'h0A.
